out_stage_pipe: RTL
===================

// Module: out_stage_pipe
// PURPOSE
//  Parametrised output stage: next generation of the single-cycle output register.
//  Carries data + valid + stall flag to the machine boundary through DEPTH elastic
//  stages and honours downstream backpressure (out_ready).
//  The stall sideband delays by a fixed DEPTH cycles, and a saturating counter
//  records cycles blocked by the consumer. Sits between writeback and machine outputs.
// PARAMETERS
//  DATA_W      8   width of data path (matches t_data in shared package)
//  DEPTH       1   number of elastic stages, legal 1..OUT_DEPTH_MAX (4); DEPTH=1 == old reg timing
//  CNT_W       16  width of blocked-cycle counter
// PORTS
//  clock        in   1       single clock, all state on posedge
//  reset        in   1       asynchronous, active-high; clears all state
//  in_valid     in   1       upstream data valid
//  in_data      in   DATA_W  upstream data
//  in_stalled   in   1       machine stall flag (sideband, no handshake)
//  in_ready     out  1       stage 0 can accept this cycle
//  out_valid    out  1       last stage holds valid data
//  out_data     out  DATA_W  last stage data
//  out_ready    in   1       consumer accepts out_data this cycle
//  out_stalled  out  1       in_stalled delayed exactly DEPTH cycles
//  blk_cnt      out  CNT_W   cycles with out_valid && !out_ready, saturating
//  blk_clr      in   1       synchronous clear of blk_cnt
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, data regs=0, stall shift=0,
//    blk_cnt=0; out_valid=0, out_data=0, out_stalled=0; in_ready=0 while reset high.
//  - Stage i advances when valid[i] && (i==last ? out_ready : (!valid[i+1] || adv[i+1])).
//    Stage i loads when empty or advancing; in_ready = !valid[0] || adv[0] (comb ready chain).
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Latency: with out_ready held 1, in_* at cycle t appears on out_* at t+DEPTH.
//  - Throughput: 1 item/cycle when out_ready=1; no bubbles inserted.
//  - Bubble collapse: an empty stage ahead of a full blocked stage still fills.
//  - Full: all DEPTH stages valid and out_ready=0 -> in_ready=0; all data held stable;
//    in_valid ignored (upstream must hold). out_ready rising -> whole chain shifts that cycle.
//  - out_data stable while out_valid && !out_ready (AXI-style hold rule).
//  - out_data when out_valid=0: holds last value, not meaningful.
//  - Stall sideband: free-running DEPTH-deep shift, independent of handshake/backpressure.
//  - blk_cnt: +1 each cycle out_valid && !out_ready; saturates at 2^CNT_W-1 (no wrap);
//    blk_clr has priority over increment (clear wins on same cycle).
//  - Reset mid-operation: in-flight items discarded, no partial output; first cycle after
//    release in_ready=1.
//  - Elaboration check: DEPTH outside 1..OUT_DEPTH_MAX -> $fatal.
// STRUCTURE
//  - Shared package: t_data typedef, OUT_DEPTH_MAX=4, OUT_CNT_W_DEF=16.
//  - Sub-module out_stage_slot: one elastic stage (valid/data reg, load/advance logic);
//    generate-loop instantiates DEPTH slots; stall shift and counter in the top.
//  - Interface-friendly: ports map onto driver/receiver modports of the output interface.
// TESTING
//  1. DEPTH=1, out_ready=1, in_valid=1 data 0x11,0x22,0x33 -> out 0x11 @t+1, 0x22 @t+2, 0x33 @t+3.
//  2. DEPTH=3, in_stalled pulse 1 cycle @t, out_ready=0 -> out_stalled=1 exactly @t+3, one cycle.
//  3. DEPTH=2, fill 0xA1,0xA2 with out_ready=0 -> in_ready=0 by 2nd cycle after fill, out_data=0xA1
//     stable; out_ready=1 -> 0xA1 then 0xA2, in_ready=1 same cycle out_ready rises.
//  4. CNT_W=4, out_valid held, out_ready=0 for 20 cycles -> blk_cnt saturates 15; blk_clr with
//     blocked same cycle -> blk_cnt=0.
//  5. DEPTH=4, 3 items in flight, assert reset mid-cycle -> out_valid=0, out_data=0, blk_cnt=0
//     immediately; after release no stale item emerges, in_ready=1.
//  6. Random in_valid/out_ready, DEPTH 1..4 -> scoreboard: in-order, no loss, no duplication.

Source files
------------

// File: rtl/out_stage_pipe_pkg.sv
// Shared definitions for the machine output stage: data type and elaboration limits.
package out_stage_pipe_pkg;

    localparam int OUT_DEPTH_MAX  = 4;
    localparam int OUT_CNT_W_DEF  = 16;
    localparam int OUT_DATA_W_DEF = 8;

    typedef logic [OUT_DATA_W_DEF-1:0] t_data;

endpackage

// File: rtl/out_stage_slot.sv
// One elastic stage: a valid/data register that reloads whenever it is empty or
// its current item is being taken downstream.
module out_stage_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              dn_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        ready   = !valid_q || dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        // data only moves on a real load, so an emptied stage keeps its last value
        if (ready) begin
            valid_d = up_valid;
            if (up_valid) data_d = up_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/out_stage_pipe.sv
// Machine output stage: DEPTH elastic slots with a combinational ready chain,
// a fixed-delay stall sideband and a saturating blocked-cycle counter.
module out_stage_pipe
    import out_stage_pipe_pkg::*;
#(
    parameter int DATA_W = OUT_DATA_W_DEF,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = OUT_CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_stalled,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_stalled,
    output logic [CNT_W-1:0]  blk_cnt,
    input  logic              blk_clr
);

    if (DEPTH < 1 || DEPTH > OUT_DEPTH_MAX) begin : g_bad_depth
        $fatal(1, "out_stage_pipe: DEPTH must be within 1..OUT_DEPTH_MAX");
    end

    logic [DEPTH-1:0]             s_valid;
    logic [DEPTH-1:0]             s_ready;
    logic [DEPTH-1:0]             s_up_valid;
    logic [DEPTH-1:0]             s_dn_ready;
    logic [DEPTH-1:0][DATA_W-1:0] s_up_data;
    logic [DEPTH-1:0][DATA_W-1:0] s_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign s_up_valid[i] = in_valid;
            assign s_up_data[i]  = in_data;
        end else begin : g_body
            assign s_up_valid[i] = s_valid[i-1];
            assign s_up_data[i]  = s_data[i-1];
        end
        if (i == DEPTH - 1) begin : g_tail
            assign s_dn_ready[i] = out_ready;
        end else begin : g_link
            assign s_dn_ready[i] = s_ready[i+1];
        end

        out_stage_slot #(.DATA_W(DATA_W)) u_slot (
            .clock    (clock),
            .reset    (reset),
            .up_valid (s_up_valid[i]),
            .up_data  (s_up_data[i]),
            .dn_ready (s_dn_ready[i]),
            .valid    (s_valid[i]),
            .data     (s_data[i]),
            .ready    (s_ready[i])
        );
    end

    // upstream sees not-ready for the whole time reset is held
    assign in_ready  = !reset && s_ready[0];
    assign out_valid = s_valid[DEPTH-1];
    assign out_data  = s_data[DEPTH-1];

    logic [DEPTH-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] blk_q,   blk_d;

    always_comb begin
        stall_d    = stall_q;
        stall_d[0] = in_stalled;
        for (int i = 1; i < DEPTH; i++) stall_d[i] = stall_q[i-1];

        blk_d = blk_q;
        if (blk_clr)
            blk_d = '0;
        else if (out_valid && !out_ready && blk_q != {CNT_W{1'b1}})
            blk_d = blk_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            blk_q   <= '0;
        end else begin
            stall_q <= stall_d;
            blk_q   <= blk_d;
        end
    end

    assign out_stalled = stall_q[DEPTH-1];
    assign blk_cnt     = blk_q;

endmodule
